// File: rtl/instruction_fetch.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Holds the PC and a small instruction memory, and issues fetched words to decode.
// Supports stall, flush, halt and a boot-time load port (written only while run=0).
// Optional build macro: IF_PERF_CNT_EN adds saturating fetch_cnt / stall_cnt outputs.
module instruction_fetch #(
    parameter int unsigned IW      = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned HALT_OP = 7
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    input  logic          stall,
    input  logic          flush,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    output logic [AW-1:0] pc,
    output logic          id_valid,
    output logic [AW-1:0] id_pc,
    output logic [IW-1:0] id_inst,
    output logic [2:0]    id_opcode,
    output logic [2:0]    id_rd,
    output logic [2:0]    id_rs1,
    output logic [2:0]    id_rs2,
    output logic [3:0]    id_imm,
    output logic          halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]   fetch_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] fetch_word_c;
    logic          is_halt_c;
    logic          fetch_en_c;
    logic          issue_c;

    // Combinational read of the word at the current PC
    assign fetch_word_c = mem[pc];
    assign is_halt_c    = (fetch_word_c[IW-1 -: 3] == 3'(HALT_OP));
    assign fetch_en_c   = rstn && !flush && !stall && run && (state == ST_RUN);
    assign issue_c      = fetch_en_c && !is_halt_c;

    // Load port: writes only while fetch is idle, so no same-address read/write clash
    always_ff @(posedge clk) begin
        if (load_we && !run) begin
            mem[load_addr] <= load_data;
        end
    end

    // Fetch FSM and IF/ID register; priority reset > flush > stall > halt/idle > fetch
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_RUN;
            pc       <= '0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
        end else if (stall) begin
            id_valid <= id_valid;
        end else begin
            case (state)
                ST_HALT: begin
                    id_valid <= 1'b0;
                end
                default: begin
                    if (!run) begin
                        id_valid <= 1'b0;
                    end else if (is_halt_c) begin
                        // HALT word is never issued; PC parks on it until reset
                        state    <= ST_HALT;
                        id_valid <= 1'b0;
                    end else begin
                        id_inst  <= fetch_word_c;
                        id_pc    <= pc;
                        id_valid <= 1'b1;
                        pc       <= AW'(pc + 1'b1);
                    end
                end
            endcase
        end
    end

    assign halted = (state == ST_HALT);

    // Decode fields are plain slices of the registered instruction word
    assign id_opcode = id_inst[IW-1 -: 3];
    assign id_rd     = id_inst[IW-4 -: 3];
    assign id_rs1    = id_inst[IW-7 -: 3];
    assign id_rs2    = id_inst[IW-10 -: 3];
    assign id_imm    = id_inst[3:0];

`ifdef IF_PERF_CNT_EN
    // Saturating counters of issued instructions and stalled running cycles
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue_c && (fetch_cnt != 16'hFFFF)) begin
                fetch_cnt <= 16'(fetch_cnt + 1'b1);
            end
            if (stall && !flush && run && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= 16'(stall_cnt + 1'b1);
            end
        end
    end
`endif

endmodule
